// File: rtl/vga_timing_pkg.sv
// Shared VGA timing sets (640x480@60, 800x600@60) and sync polarity levels.
package vga_timing_pkg;
  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam bit VGA640_H_POL    = SYNC_ACTIVE_LOW;
  localparam bit VGA640_V_POL    = SYNC_ACTIVE_LOW;

  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam bit SVGA800_H_POL    = SYNC_ACTIVE_HIGH;
  localparam bit SVGA800_V_POL    = SYNC_ACTIVE_HIGH;

  function automatic logic sync_level(input logic in_window, input bit pol);
    return in_window ? pol : ~pol;
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen (master) to the pixel pipeline (slave).
interface vga_timing_gen_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic          h_sync;
  logic          v_sync;
  logic          on_screen;
  logic [XW-1:0] pixel_x;
  logic [YW-1:0] pixel_y;
  logic          line_start;
  logic          frame_start;
  logic          pix_tick;

  modport master (
    output h_sync, v_sync, on_screen, pixel_x, pixel_y, line_start, frame_start, pix_tick
  );
  modport slave (
    input h_sync, v_sync, on_screen, pixel_x, pixel_y, line_start, frame_start, pix_tick
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter wrapping at ACTIVE+FP+SYNC+BP, plus combinational
// active-region and sync-window decode of the current count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = SYNC_ACTIVE_LOW,
  parameter int W      = $clog2(ACTIVE + FP + SYNC + BP)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         active,
  output logic         sync
);
  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  logic [W-1:0] r_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= wrap ? '0 : r_count + 1'b1;
    end
  end

  assign count  = r_count;
  assign wrap   = (r_count == W'(TOTAL - 1));
  assign active = (r_count < W'(ACTIVE));
  assign sync   = sync_level((r_count >= W'(ACTIVE + FP)) && (r_count < W'(ACTIVE + FP + SYNC)), POL);
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: two axis counters feed a registered decode stage, so all outputs lag the counters by one tick.
// VGA_TIMING_PRESCALE_EN adds a CLK_DIV prescaler for pix_tick; without it every CLK is a tick.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit H_POL    = VGA640_H_POL,
  parameter bit V_POL    = VGA640_V_POL,
  parameter int CLK_DIV  = 1
) (
  input  logic             CLK,
  input  logic             RST,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);

  logic          w_tick;
  logic          w_v_inc;
  logic [XW-1:0] w_hc;
  logic [YW-1:0] w_vc;
  logic          w_h_wrap, w_v_wrap;
  logic          w_h_act, w_v_act;
  logic          w_h_sync, w_v_sync;

`ifdef VGA_TIMING_PRESCALE_EN
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] r_div;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_tick = ~RST & (r_div == DW'(CLK_DIV - 1));
`else
  assign w_tick = ~RST;
`endif

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .W(XW)
  ) u_h_axis (
    .CLK(CLK), .RST(RST), .inc(w_tick), .count(w_hc),
    .wrap(w_h_wrap), .active(w_h_act), .sync(w_h_sync)
  );

  assign w_v_inc = w_h_wrap & w_tick;

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .W(YW)
  ) u_v_axis (
    .CLK(CLK), .RST(RST), .inc(w_v_inc), .count(w_vc),
    .wrap(w_v_wrap), .active(w_v_act), .sync(w_v_sync)
  );

  // r_at_line/r_at_origin flag that the counters sit at x=0 / (0,0) this tick,
  // replacing wide zero compares with the wrap flags of the previous tick.
  logic          r_at_line, r_at_origin;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_on, r_ls, r_fs, r_hs, r_vs;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_at_line   <= 1'b1;
      r_at_origin <= 1'b1;
      r_x         <= '0;
      r_y         <= '0;
      r_on        <= 1'b0;
      r_ls        <= 1'b0;
      r_fs        <= 1'b0;
      r_hs        <= ~H_POL;
      r_vs        <= ~V_POL;
    end else if (w_tick) begin
      r_at_line   <= w_h_wrap;
      r_at_origin <= w_h_wrap & w_v_wrap;
      r_x         <= w_hc;
      r_y         <= w_vc;
      r_on        <= w_h_act & w_v_act;
      r_ls        <= r_at_line;
      r_fs        <= r_at_origin;
      r_hs        <= w_h_sync;
      r_vs        <= w_v_sync;
    end
  end

  assign vga.h_sync      = r_hs;
  assign vga.v_sync      = r_vs;
  assign vga.on_screen   = r_on;
  assign vga.pixel_x     = r_x;
  assign vga.pixel_y     = r_y;
  assign vga.line_start  = r_ls;
  assign vga.frame_start = r_fs;
  assign vga.pix_tick    = w_tick;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 plus two small timing sets, checked against a position-from-tick-count model.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

`ifdef VGA_TIMING_PRESCALE_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif

  typedef struct {
    int ha, hf, hsw, hb, va, vf, vsw, vb;
    bit hp, vp;
  } tim_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic hs, vs, on, ls, fs;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   k = 0;
  int   checks = 0;
  int   failures = 0;
  tim_t T_DEF, T_SML, T_MED;

  always #5 clk = ~clk;

  // Active CLK edges since the last reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  vga_timing_gen_if #(.XW(10), .YW(10)) if_def ();
  vga_timing_gen_if #(.XW(3),  .YW(3))  if_sml ();
  vga_timing_gen_if #(.XW(4),  .YW(4))  if_med ();

  vga_timing_gen #(.CLK_DIV(4)) u_def (.CLK(clk), .RST(rst), .vga(if_def));

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(SYNC_ACTIVE_HIGH), .V_POL(SYNC_ACTIVE_HIGH), .CLK_DIV(4)
  ) u_sml (.CLK(clk), .RST(rst), .vga(if_sml));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(SYNC_ACTIVE_LOW), .V_POL(SYNC_ACTIVE_LOW), .CLK_DIV(4)
  ) u_med (.CLK(clk), .RST(rst), .vga(if_med));

  // Tick n (n>=1) shows raster position n-1 in scan order; n=0 means no tick yet.
  function automatic obs_t model(input tim_t t, input int n);
    obs_t e;
    int   ht, vt, p, x, y;
    ht = t.ha + t.hf + t.hsw + t.hb;
    vt = t.va + t.vf + t.vsw + t.vb;
    e = '0;
    e.hs = ~t.hp;
    e.vs = ~t.vp;
    if (n > 0) begin
      p = (n - 1) % (ht * vt);
      x = p % ht;
      y = p / ht;
      e.x  = 16'(x);
      e.y  = 16'(y);
      e.on = (x < t.ha) && (y < t.va);
      e.ls = (x == 0);
      e.fs = (x == 0) && (y == 0);
      if (x >= t.ha + t.hf && x < t.ha + t.hf + t.hsw) e.hs = t.hp;
      if (y >= t.va + t.vf && y < t.va + t.vf + t.vsw) e.vs = t.vp;
    end
    return e;
  endfunction

  function automatic logic exp_tick();
    return (rst == 1'b0) && (((k + 1) % D) == 0);
  endfunction

  function automatic obs_t obs_def();
    obs_t o;
    o.x = 16'(if_def.pixel_x); o.y = 16'(if_def.pixel_y);
    o.hs = if_def.h_sync; o.vs = if_def.v_sync; o.on = if_def.on_screen;
    o.ls = if_def.line_start; o.fs = if_def.frame_start;
    return o;
  endfunction

  function automatic obs_t obs_sml();
    obs_t o;
    o.x = 16'(if_sml.pixel_x); o.y = 16'(if_sml.pixel_y);
    o.hs = if_sml.h_sync; o.vs = if_sml.v_sync; o.on = if_sml.on_screen;
    o.ls = if_sml.line_start; o.fs = if_sml.frame_start;
    return o;
  endfunction

  function automatic obs_t obs_med();
    obs_t o;
    o.x = 16'(if_med.pixel_x); o.y = 16'(if_med.pixel_y);
    o.hs = if_med.h_sync; o.vs = if_med.v_sync; o.on = if_med.on_screen;
    o.ls = if_med.line_start; o.fs = if_med.frame_start;
    return o;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (obs_def() !== model(T_DEF, 0)) begin failures++; $display("FAIL reset_def got=%h exp=%h", obs_def(), model(T_DEF, 0)); end
    checks++; if (obs_sml() !== model(T_SML, 0)) begin failures++; $display("FAIL reset_sml got=%h exp=%h", obs_sml(), model(T_SML, 0)); end
    checks++; if (obs_med() !== model(T_MED, 0)) begin failures++; $display("FAIL reset_med got=%h exp=%h", obs_med(), model(T_MED, 0)); end
    checks++; if (if_def.pix_tick !== 1'b0) begin failures++; $display("FAIL reset_pix_tick got=%b exp=0", if_def.pix_tick); end
  endtask

  task automatic test_timing_sweep(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      checks++; if (obs_def() !== model(T_DEF, k / D)) begin failures++; $display("FAIL sweep_def k=%0d got=%h exp=%h", k, obs_def(), model(T_DEF, k / D)); end
      checks++; if (obs_sml() !== model(T_SML, k / D)) begin failures++; $display("FAIL sweep_sml k=%0d got=%h exp=%h", k, obs_sml(), model(T_SML, k / D)); end
      checks++; if (obs_med() !== model(T_MED, k / D)) begin failures++; $display("FAIL sweep_med k=%0d got=%h exp=%h", k, obs_med(), model(T_MED, k / D)); end
      checks++; if (if_def.pix_tick !== exp_tick()) begin failures++; $display("FAIL sweep_pix_tick k=%0d got=%b exp=%b", k, if_def.pix_tick, exp_tick()); end
    end
  endtask

  task automatic test_hsync_line();
    int b, low, wid, gap;
    b = 0;
    while (if_def.h_sync !== 1'b1 && b < 1000 * D) begin @(negedge clk); b++; end
    b = 0;
    while (if_def.h_sync !== 1'b0 && b < 1000 * D) begin @(negedge clk); b++; end
    checks++; if (b >= 1000 * D) begin failures++; $display("FAIL hsync_fall timeout got=%0d cycles exp<%0d", b, 1000 * D); end
    checks++; if (if_def.pixel_x !== 10'd656) begin failures++; $display("FAIL hsync_start_x got=%0d exp=656", if_def.pixel_x); end
    low = 0;
    while (if_def.h_sync === 1'b0 && low < 1000 * D) begin @(negedge clk); low++; end
    checks++; if (low !== 96 * D) begin failures++; $display("FAIL hsync_width got=%0d exp=%0d", low, 96 * D); end
    b = 0;
    while (if_def.line_start !== 1'b1 && b < 1000 * D) begin @(negedge clk); b++; end
    wid = 0;
    while (if_def.line_start === 1'b1 && wid < 1000 * D) begin @(negedge clk); wid++; end
    gap = 0;
    while (if_def.line_start !== 1'b1 && gap < 1000 * D) begin @(negedge clk); gap++; end
    checks++; if (wid !== D) begin failures++; $display("FAIL line_start_width got=%0d exp=%0d", wid, D); end
    checks++; if (wid + gap !== 800 * D) begin failures++; $display("FAIL line_period got=%0d exp=%0d", wid + gap, 800 * D); end
  endtask

  task automatic test_frame_counts();
    int b, hs_n, vs_n, on_n, fs_n;
    b = 0;
    while (if_sml.frame_start !== 1'b0 && b < 100 * D) begin @(negedge clk); b++; end
    while (if_sml.frame_start !== 1'b1 && b < 100 * D) begin @(negedge clk); b++; end
    checks++; if (b >= 100 * D) begin failures++; $display("FAIL sml_align timeout got=%0d", b); end
    hs_n = 0; vs_n = 0; on_n = 0; fs_n = 0;
    for (int i = 0; i < 42 * D; i++) begin
      if (if_sml.h_sync === 1'b1) hs_n++;
      if (if_sml.v_sync === 1'b1) vs_n++;
      if (if_sml.on_screen === 1'b1) on_n++;
      if (if_sml.frame_start === 1'b1) fs_n++;
      @(negedge clk);
    end
    checks++; if (hs_n !== 6 * D)  begin failures++; $display("FAIL sml_hsync_cnt got=%0d exp=%0d", hs_n, 6 * D); end
    checks++; if (vs_n !== 7 * D)  begin failures++; $display("FAIL sml_vsync_cnt got=%0d exp=%0d", vs_n, 7 * D); end
    checks++; if (on_n !== 12 * D) begin failures++; $display("FAIL sml_on_cnt got=%0d exp=%0d", on_n, 12 * D); end
    checks++; if (fs_n !== D)      begin failures++; $display("FAIL sml_fs_cnt got=%0d exp=%0d", fs_n, D); end
    checks++; if (if_sml.frame_start !== 1'b1) begin failures++; $display("FAIL sml_frame_period got=%b exp=1", if_sml.frame_start); end

    b = 0;
    while (if_med.frame_start !== 1'b0 && b < 300 * D) begin @(negedge clk); b++; end
    while (if_med.frame_start !== 1'b1 && b < 300 * D) begin @(negedge clk); b++; end
    checks++; if (b >= 300 * D) begin failures++; $display("FAIL med_align timeout got=%0d", b); end
    hs_n = 0; vs_n = 0; on_n = 0;
    for (int i = 0; i < 135 * D; i++) begin
      if (if_med.h_sync === 1'b0) hs_n++;
      if (if_med.v_sync === 1'b0) vs_n++;
      if (if_med.on_screen === 1'b1) on_n++;
      @(negedge clk);
    end
    checks++; if (hs_n !== 27 * D) begin failures++; $display("FAIL med_hsync_low got=%0d exp=%0d", hs_n, 27 * D); end
    checks++; if (vs_n !== 30 * D) begin failures++; $display("FAIL med_vsync_low got=%0d exp=%0d", vs_n, 30 * D); end
    checks++; if (on_n !== 40 * D) begin failures++; $display("FAIL med_on_cnt got=%0d exp=%0d", on_n, 40 * D); end
  endtask

  task automatic test_last_pixel();
    int   b;
    obs_t e;
    b = 0;
    while (!(if_sml.pixel_x === 3'd6 && if_sml.pixel_y === 3'd5) && b < 100 * D) begin @(negedge clk); b++; end
    checks++; if (b >= 100 * D) begin failures++; $display("FAIL sml_last_reach timeout got=%0d", b); end
    b = 0;
    while (if_sml.pix_tick !== 1'b1 && b < 2 * D) begin @(negedge clk); b++; end
    @(negedge clk);
    e = '0; e.on = 1'b1; e.ls = 1'b1; e.fs = 1'b1;
    checks++; if (obs_sml() !== e) begin failures++; $display("FAIL sml_wrap got=%h exp=%h", obs_sml(), e); end

    b = 0;
    while (!(if_med.pixel_x === 4'd14 && if_med.pixel_y === 4'd8) && b < 300 * D) begin @(negedge clk); b++; end
    checks++; if (b >= 300 * D) begin failures++; $display("FAIL med_last_reach timeout got=%0d", b); end
    b = 0;
    while (if_med.pix_tick !== 1'b1 && b < 2 * D) begin @(negedge clk); b++; end
    @(negedge clk);
    e = '0; e.hs = 1'b1; e.vs = 1'b1; e.on = 1'b1; e.ls = 1'b1; e.fs = 1'b1;
    checks++; if (obs_med() !== e) begin failures++; $display("FAIL med_wrap got=%h exp=%h", obs_med(), e); end
  endtask

  task automatic test_reset_midframe();
    int   b, tx;
    obs_t e;
    for (int it = 0; it < 3; it++) begin
      tx = (it == 0) ? 300 : int'($urandom_range(0, 799));
      b = 0;
      while (if_def.pixel_x !== 10'(tx) && b < 900 * D) begin @(negedge clk); b++; end
      checks++; if (b >= 900 * D) begin failures++; $display("FAIL midrst_reach x=%0d timeout got=%0d", tx, b); end
      #2 rst = 1'b1;
      #1;
      checks++; if (obs_def() !== model(T_DEF, 0)) begin failures++; $display("FAIL midrst_def_async got=%h exp=%h", obs_def(), model(T_DEF, 0)); end
      checks++; if (obs_med() !== model(T_MED, 0)) begin failures++; $display("FAIL midrst_med_async got=%h exp=%h", obs_med(), model(T_MED, 0)); end
      checks++; if (if_def.pix_tick !== 1'b0) begin failures++; $display("FAIL midrst_pix_tick got=%b exp=0", if_def.pix_tick); end
      repeat ($urandom_range(1, 4)) @(negedge clk);
      checks++; if (obs_sml() !== model(T_SML, 0)) begin failures++; $display("FAIL midrst_sml_hold got=%h exp=%h", obs_sml(), model(T_SML, 0)); end
      rst = 1'b0;
      repeat (D) @(negedge clk);
      e = '0; e.hs = 1'b1; e.vs = 1'b1; e.on = 1'b1; e.ls = 1'b1; e.fs = 1'b1;
      checks++; if (obs_def() !== e) begin failures++; $display("FAIL midrst_first_tick got=%h exp=%h", obs_def(), e); end
      test_timing_sweep(int'($urandom_range(50, 300)));
    end
  endtask

  initial begin
    T_DEF = '{ha: VGA640_H_ACTIVE, hf: VGA640_H_FP, hsw: VGA640_H_SYNC, hb: VGA640_H_BP,
              va: VGA640_V_ACTIVE, vf: VGA640_V_FP, vsw: VGA640_V_SYNC, vb: VGA640_V_BP,
              hp: SYNC_ACTIVE_LOW, vp: SYNC_ACTIVE_LOW};
    T_SML = '{ha: 4, hf: 1, hsw: 1, hb: 1, va: 3, vf: 1, vsw: 1, vb: 1,
              hp: SYNC_ACTIVE_HIGH, vp: SYNC_ACTIVE_HIGH};
    T_MED = '{ha: 8, hf: 2, hsw: 3, hb: 2, va: 5, vf: 1, vsw: 2, vb: 1,
              hp: SYNC_ACTIVE_LOW, vp: SYNC_ACTIVE_LOW};

    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_timing_sweep(2500 * D);
    test_hsync_line();
    test_frame_counts();
    test_last_pixel();
    test_reset_midframe();
    test_timing_sweep(int'($urandom_range(100, 400)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
